// File: rtl/vx_fifo_drain_arbiter.sv
// rtl/vx_fifo_drain_arbiter.sv - round-robin burst drain of several source queues into one registered output
module vx_fifo_drain_arbiter #(
  parameter int NUM_REQS  = 4,
  parameter int DATAW     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           q_empty,
  input  logic [NUM_REQS*DATAW-1:0]     q_data,
  output logic [NUM_REQS-1:0]           q_pop,
  output logic                          out_valid,
  output logic [DATAW-1:0]              out_data,
  output logic [$clog2(NUM_REQS)-1:0]   out_index,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int IDXW = $clog2(NUM_REQS);
  localparam int CNTW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [IDXW-1:0]   rr_ptr, rr_n;
  logic [IDXW-1:0]   grant_idx, grant_n, grant_inc;
  logic [CNTW-1:0]   burst_cnt, cnt_n;
  logic              out_valid_n;
  logic [DATAW-1:0]  data_n;
  logic [IDXW-1:0]   index_n;

  logic              any_req, can_issue, pop, last_pop, found;
  logic [IDXW-1:0]   rr_sel, cand;
  logic [IDXW:0]     sum;

  assign any_req   = ~&q_empty;
  assign can_issue = ~out_valid | out_ready;
  assign busy      = (state == BURST);

  // Pops are gated by reset so nothing leaves a source queue while the burst is abandoned.
  assign pop       = (state == BURST) && can_issue && !q_empty[grant_idx] && !reset;
  assign last_pop  = pop && (burst_cnt == CNTW'(MAX_BURST - 1));
  assign grant_inc = (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

  // First non-empty queue at or after rr_ptr, wrapping modulo NUM_REQS.
  always_comb begin
    rr_sel = rr_ptr;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      sum = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(NUM_REQS)) begin
        sum = sum - (IDXW+1)'(NUM_REQS);
      end
      cand = sum[IDXW-1:0];
      if (!found && !q_empty[cand]) begin
        found  = 1'b1;
        rr_sel = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant_idx;
    cnt_n       = burst_cnt;
    rr_n        = rr_ptr;
    out_valid_n = out_valid & ~out_ready;
    data_n      = out_data;
    index_n     = out_index;
    q_pop       = '0;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_n = rr_sel;
          cnt_n   = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          q_pop[grant_idx] = 1'b1;
          out_valid_n      = 1'b1;
          data_n           = q_data[grant_idx*DATAW +: DATAW];
          index_n          = grant_idx;
          cnt_n            = burst_cnt + 1'b1;
        end
        if (last_pop || q_empty[grant_idx]) begin
          state_n = IDLE;
          rr_n    = grant_inc;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      grant_idx <= grant_n;
      burst_cnt <= cnt_n;
      out_valid <= out_valid_n;
    end
  end

  // Output payload carries no reset; it only moves on a pop.
  always_ff @(posedge clk) begin
    out_data  <= data_n;
    out_index <= index_n;
  end

endmodule

// File: tb/tb_vx_fifo_drain_arbiter.sv
// tb/tb_vx_fifo_drain_arbiter.sv - self-checking bench for vx_fifo_drain_arbiter
module tb_vx_fifo_drain_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int MB    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 16384;

  logic            clk, reset;
  logic [N-1:0]    q_empty, q_pop;
  logic [N*DW-1:0] q_data;
  logic            out_valid, out_ready, busy;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_index;

  vx_fifo_drain_arbiter #(.NUM_REQS(N), .DATAW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .q_empty(q_empty), .q_data(q_data), .q_pop(q_pop),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          exp_q[$];
  logic [DW-1:0] src_mem [N][DEPTH];
  int            head[N], tail[N];
  int            cyc_pop[$];
  logic          cyc_busy[$], cyc_ov[$];
  logic [DW-1:0] cyc_od[$];
  logic [DW-1:0] acc_data[$];
  int            acc_idx[$];
  int            n_cmp, n_err, n_push, n_acc, acc0;
  logic          prev_pop, prev_rst;
  logic [DW-1:0] prev_od;
  logic [IW-1:0] prev_oi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      q_empty[i] = (head[i] == tail[i]);
      q_data[i*DW +: DW] = (head[i] != tail[i]) ? src_mem[i][head[i]] : '0;
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d);
    src_mem[i][tail[i]] = d;
    tail[i]++;
    n_push++;
  endtask

  task automatic clear_logs();
    cyc_pop.delete(); cyc_busy.delete(); cyc_ov.delete(); cyc_od.delete();
    acc_data.delete(); acc_idx.delete();
  endtask

  // One clock: sample at negedge, then update the queue/scoreboard model after the edge.
  task automatic cycle();
    logic [N-1:0]  pop_s;
    logic          ov_s, rdy_s, rst_s, busy_s;
    logic [DW-1:0] od_s;
    logic [IW-1:0] oi_s;
    int            p;
    ent_t          e;
    refresh();
    @(negedge clk);
    pop_s = q_pop; ov_s = out_valid; rdy_s = out_ready; rst_s = reset;
    busy_s = busy; od_s = out_data; oi_s = out_index;
    chk("pop_onehot0", 64'($onehot0(pop_s)), 64'd1);
    chk("pop_on_empty", 64'(pop_s & q_empty), 64'd0);
    if (rst_s) chk("pop_in_reset", 64'(pop_s), 64'd0);
    if (!rst_s) chk("out_valid_model", 64'(ov_s), 64'(exp_q.size() != 0));
    if (!prev_pop && !prev_rst) begin
      chk("out_data_hold", 64'(od_s), 64'(prev_od));
      chk("out_index_hold", 64'(oi_s), 64'(prev_oi));
    end
    p = -1;
    for (int i = 0; i < N; i++) if (pop_s[i]) p = i;
    cyc_pop.push_back(p); cyc_busy.push_back(busy_s);
    cyc_ov.push_back(ov_s); cyc_od.push_back(od_s);
    @(posedge clk);
    #1;
    if (rst_s) begin
      exp_q.delete();
    end else begin
      if (ov_s && rdy_s) begin
        chk("accept_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("accept_data", 64'(od_s), 64'(e.data));
          chk("accept_index", 64'(oi_s), 64'(e.idx));
          acc_data.push_back(od_s);
          acc_idx.push_back(int'(oi_s));
          n_acc++;
        end
      end
      if (p >= 0 && head[p] != tail[p]) begin
        e.idx = p;
        e.data = src_mem[p][head[p]];
        exp_q.push_back(e);
        head[p]++;
      end
    end
    prev_pop = (p >= 0); prev_rst = rst_s; prev_od = od_s; prev_oi = oi_s;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    int  e;
    logic done;
    n_cmp = 0; n_err = 0; n_push = 0; n_acc = 0;
    prev_pop = 1'b0; prev_rst = 1'b1; prev_od = '0; prev_oi = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    reset = 1'b1; out_ready = 1'b1;
    refresh();
    run(2);
    reset = 1'b0;
    clear_logs();
    run(1);
    chk("reset_out_valid", 64'(cyc_ov[0]), 64'd0);
    chk("reset_busy", 64'(cyc_busy[0]), 64'd0);
    chk("reset_no_pop", 64'(cyc_pop[0]), 64'(-1));

    // Only q1 non-empty: one burst of MB pops, then an idle cycle.
    do_reset();
    for (int k = 0; k < 6; k++) push(1, 32'(16 + k));
    run(8);
    chk("A_grant_no_pop", 64'(cyc_pop[0]), 64'(-1));
    for (int c = 1; c <= 4; c++) chk("A_pop_q1", 64'(cyc_pop[c]), 64'd1);
    chk("A_idle_after_burst", 64'(cyc_busy[5]), 64'd0);
    chk("A_accepted_4", 64'(acc_data.size() >= 4), 64'd1);
    for (int k = 0; k < 4 && k < acc_data.size(); k++) begin
      chk("A_out_data", 64'(acc_data[k]), 64'(16 + k));
      chk("A_out_index", 64'(acc_idx[k]), 64'd1);
    end

    // All queues busy: index order 0..3, MB pops each, one idle cycle per burst.
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 10; k++) push(i, 32'(i*16 + k));
    run(22);
    for (int c = 0; c < 22; c++) begin
      e = (c % (MB + 1) == 0) ? -1 : (c / (MB + 1)) % N;
      chk("B_pop_sequence", 64'(cyc_pop[c]), 64'(e));
    end
    chk("B_accepted_16", 64'(acc_data.size() >= 16), 64'd1);
    for (int k = 0; k < 16 && k < acc_data.size(); k++) begin
      chk("B_out_data", 64'(acc_data[k]), 64'(((k / MB) % N) * 16 + (k % MB) + MB * (k / (MB * N))));
      chk("B_out_index", 64'(acc_idx[k]), 64'((k / MB) % N));
    end

    // q2 with two entries: two pops, release on empty, rr_ptr moves to 3.
    do_reset();
    push(2, 32'd32); push(2, 32'd33);
    run(5);
    chk("C_grant", 64'(cyc_pop[0]), 64'(-1));
    chk("C_pop1", 64'(cyc_pop[1]), 64'd2);
    chk("C_pop2", 64'(cyc_pop[2]), 64'd2);
    chk("C_no_third_pop", 64'(cyc_pop[3]), 64'(-1));
    chk("C_release_seen_busy", 64'(cyc_busy[3]), 64'd1);
    chk("C_idle", 64'(cyc_busy[4]), 64'd0);
    chk("C_no_pop_idle", 64'(cyc_pop[4]), 64'(-1));
    clear_logs();
    push(0, 32'd0); push(3, 32'd48);
    run(4);
    chk("C_rr_ptr_3", 64'(cyc_pop[1]), 64'd3);

    // Backpressure mid-burst holds everything; burst count survives the stall.
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 10; k++) push(i, 32'(i*16 + k));
    run(3);
    out_ready = 1'b0;
    run(5);
    for (int c = 3; c < 8; c++) begin
      chk("D_stall_no_pop", 64'(cyc_pop[c]), 64'(-1));
      chk("D_stall_data", 64'(cyc_od[c]), 64'd1);
      chk("D_stall_valid", 64'(cyc_ov[c]), 64'd1);
    end
    out_ready = 1'b1;
    run(5);
    chk("D_resume_pop3", 64'(cyc_pop[8]), 64'd0);
    chk("D_resume_pop4", 64'(cyc_pop[9]), 64'd0);
    chk("D_burst_end", 64'(cyc_pop[10]), 64'(-1));
    chk("D_next_queue", 64'(cyc_pop[11]), 64'd1);

    // Reset in the middle of a burst abandons it and restarts arbitration at q0.
    do_reset();
    for (int k = 0; k < 10; k++) push(1, 32'(16 + k));
    run(8);
    chk("E_regrant", 64'(cyc_pop[5]), 64'(-1));
    chk("E_pop_a", 64'(cyc_pop[6]), 64'd1);
    chk("E_pop_b", 64'(cyc_pop[7]), 64'd1);
    for (int i = 0; i < N; i++) if (i != 1) for (int k = 0; k < 10; k++) push(i, 32'(i*16 + k));
    reset = 1'b1;
    run(1);
    chk("E_no_pop_in_reset", 64'(cyc_pop[8]), 64'(-1));
    reset = 1'b0;
    run(2);
    chk("E_out_valid_cleared", 64'(cyc_ov[9]), 64'd0);
    chk("E_busy_cleared", 64'(cyc_busy[9]), 64'd0);
    chk("E_no_pop_after_reset", 64'(cyc_pop[9]), 64'(-1));
    chk("E_restart_q0", 64'(cyc_pop[10]), 64'd0);

    // Random occupancy and backpressure against the scoreboard.
    do_reset();
    n_push = 0;
    acc0 = n_acc;
    for (int t = 0; t < 10000; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if ((tail[i] - head[i]) < 4 && $urandom_range(0, 2) == 0) push(i, 32'((i << 24) | tail[i]));
      cycle();
      if (cyc_pop.size() > 64) clear_logs();
    end
    out_ready = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      cycle();
      done = (exp_q.size() == 0) && !out_valid;
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 1'b0;
    end
    chk("F_drained", 64'(done), 64'd1);
    chk("F_all_delivered", 64'(n_acc - acc0), 64'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
